// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: ALU control codes and FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_SRAI = 3'b100;
    localparam logic [2:0] ALU_ADDI = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_MUL  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: retires MUL_STEP multiplier bits per cycle, LSB first.
// done_o flags the final step; product_o is the accumulator value that step produces.
module alu_mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int N     = WIDTH / MUL_STEP;
    localparam int CNT_W = $clog2(N + 1);

    logic [WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0] mplier_p0;
    logic [WIDTH-1:0] acc_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_nxt;

    // Partial product of the multiplicand with the next MUL_STEP multiplier bits;
    // bits shifted past WIDTH are dropped, giving the low half of the product.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_p0[i]) begin
                partial = partial + (mcand_p0 << i);
            end
        end
    end

    assign acc_nxt   = acc_p0 + partial;
    assign product_o = acc_nxt;
    assign done_o    = (cnt_p0 == CNT_W'(1));

    // Operand registers are pure data and need no reset; control and accumulator do.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_p0 <= '0;
            acc_p0 <= '0;
        end else if (start_i) begin
            cnt_p0 <= CNT_W'(N);
            acc_p0 <= '0;
        end else if (cnt_p0 != '0) begin
            cnt_p0 <= cnt_p0 - CNT_W'(1);
            acc_p0 <= acc_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_i) begin
            mcand_p0  <= a_i;
            mplier_p0 <= b_i;
        end else if (cnt_p0 != '0) begin
            mcand_p0  <= mcand_p0 << MUL_STEP;
            mplier_p0 <= mplier_p0 >> MUL_STEP;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative multiply
// that deasserts ready_o while busy so the hazard unit can stall the front end.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [TAG_W-1:0] rd_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic [TAG_W-1:0] rd_o
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_e       state_p0;
    alu_state_e       state_nxt;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic             load_res;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] res_nxt;
    logic [TAG_W-1:0] rd_nxt;
    logic [TAG_W-1:0] mul_rd_p0;

    function automatic logic [WIDTH-1:0] shift_ra(input logic [WIDTH-1:0] a,
                                                  input logic [SH_W-1:0]  sh);
        logic signed [WIDTH-1:0] a_s;
        a_s = signed'(a);
        return a_s >>> sh;
    endfunction

    assign ready_o   = (state_p0 == ST_IDLE);
    assign accept    = valid_i && ready_o;
    assign is_mul    = (ALUCtrl_i == ALU_MUL);
    assign mul_start = accept && is_mul;
    assign shamt     = data2_i[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            ALU_AND:           alu_res = data1_i & data2_i;
            ALU_XOR:           alu_res = data1_i ^ data2_i;
            ALU_ADD, ALU_ADDI: alu_res = data1_i + data2_i;
            ALU_SUB:           alu_res = data1_i - data2_i;
            ALU_SLL:           alu_res = data1_i << shamt;
            ALU_SRAI:          alu_res = shift_ra(data1_i, shamt);
            default:           alu_res = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (data1_i),
        .b_i       (data2_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_nxt = state_p0;
        load_res  = 1'b0;
        res_nxt   = alu_res;
        rd_nxt    = rd_i;
        case (state_p0)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_nxt = ST_MUL;
                    end else begin
                        load_res = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // Inputs are ignored here; the completing step publishes the captured tag.
                if (mul_done) begin
                    load_res  = 1'b1;
                    res_nxt   = mul_product;
                    rd_nxt    = mul_rd_p0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output stage: result, zero flag and tag load together with the valid pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_p0 <= ST_IDLE;
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
            rd_o     <= '0;
        end else begin
            state_p0 <= state_nxt;
            valid_o  <= load_res;
            if (load_res) begin
                result_o <= res_nxt;
                zero_o   <= (res_nxt == '0);
                rd_o     <= rd_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mul_start) begin
            mul_rd_p0 <= rd_i;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed scenarios plus a randomised op stream,
// with a second instance built for four multiplier bits per cycle.
module tb_alu_exec_unit;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_SRAI = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready;
    logic [2:0]  alu_ctrl;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  rd_in;
    logic        valid_out;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd_out;

    logic        valid4_in;
    logic        ready4;
    logic [2:0]  alu_ctrl4;
    logic [31:0] data1_4;
    logic [31:0] data2_4;
    logic [4:0]  rd4_in;
    logic        valid4_out;
    logic [31:0] result4;
    logic        zero4;
    logic [4:0]  rd4_out;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    alu_exec_unit #(.WIDTH(32), .MUL_STEP(1), .TAG_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .ready_o(ready),
        .ALUCtrl_i(alu_ctrl), .data1_i(data1), .data2_i(data2), .rd_i(rd_in),
        .valid_o(valid_out), .result_o(result), .zero_o(zero), .rd_o(rd_out)
    );

    alu_exec_unit #(.WIDTH(32), .MUL_STEP(4), .TAG_W(5)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid4_in), .ready_o(ready4),
        .ALUCtrl_i(alu_ctrl4), .data1_i(data1_4), .data2_i(data2_4), .rd_i(rd4_in),
        .valid_o(valid4_out), .result_o(result4), .zero_o(zero4), .rd_o(rd4_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic [31:0]        prod;
        sa   = signed'(a);
        prod = a * b;
        case (op)
            OP_AND:         return a & b;
            OP_XOR:         return a ^ b;
            OP_ADD, OP_ADDI: return a + b;
            OP_SUB:         return a - b;
            OP_SLL:         return a << b[4:0];
            OP_SRAI:        return 32'(sa >>> b[4:0]);
            default:        return prod;
        endcase
    endfunction

    // Drives one op and records what the DUT must eventually report for it.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expected);
        exp_t e;
        valid_in = 1'b1;
        alu_ctrl = op;
        data1    = a;
        data2    = b;
        rd_in    = rd;
        e.res    = expected;
        e.rd     = rd;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        alu_ctrl = OP_AND; data1 = '0; data2 = '0; rd_in = '0;
        valid4_in = 1'b0;
        alu_ctrl4 = OP_AND; data1_4 = '0; data2_4 = '0; rd4_in = '0;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", result); end
        if (zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero: got %b expected 0", zero); end
        if (rd_out !== 5'd0) begin miscompares++; $display("FAIL reset_rd: got %0d expected 0", rd_out); end
        if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        exp_t e;
        @(negedge clk);
        issue(OP_ADD, 32'd7, 32'd5, 5'd3, 32'd12);
        @(negedge clk);
        valid_in = 1'b0;
        e = sb_q.pop_front();
        vectors += 4;
        if (valid_out !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b expected 1", valid_out); end
        if (result !== e.res) begin miscompares++; $display("FAIL add_result: got %h expected %h", result, e.res); end
        if (zero !== 1'b0) begin miscompares++; $display("FAIL add_zero: got %b expected 0", zero); end
        if (rd_out !== e.rd) begin miscompares++; $display("FAIL add_rd: got %0d expected %0d", rd_out, e.rd); end
        @(negedge clk);
        vectors += 2;
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL add_pulse: got %b expected 0", valid_out); end
        if (result !== 32'd12) begin miscompares++; $display("FAIL add_hold: got %h expected %h", result, 32'd12); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [3] = '{OP_SUB, OP_XOR, OP_SRAI};
        logic [31:0] as  [3] = '{32'd5, 32'h0000F0F0, 32'h80000000};
        logic [31:0] bs  [3] = '{32'd5, 32'h00000FF0, 32'd4};
        logic [31:0] xs  [3] = '{32'h0, 32'h0000FF00, 32'hF8000000};
        exp_t e;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb_q.pop_front();
                vectors += 4;
                if (valid_out !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i-1, valid_out); end
                if (result !== e.res) begin miscompares++; $display("FAIL b2b_result[%0d]: got %h expected %h", i-1, result, e.res); end
                if (zero !== (e.res == 32'd0)) begin miscompares++; $display("FAIL b2b_zero[%0d]: got %b expected %b", i-1, zero, e.res == 32'd0); end
                if (rd_out !== e.rd) begin miscompares++; $display("FAIL b2b_rd[%0d]: got %0d expected %0d", i-1, rd_out, e.rd); end
            end
            vectors++;
            if (ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ready); end
            if (i < 3) issue(ops[i], as[i], bs[i], 5'(i + 20), xs[i]);
            else valid_in = 1'b0;
        end
    endtask

    // Multiplies, optionally holding an add on the inputs while the unit is busy.
    task automatic test_mul(input logic hold_add, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] expected);
        exp_t e;
        int lat = 0;
        int busy = 0;
        logic got = 1'b0;
        @(negedge clk);
        issue(OP_MUL, a, b, rd, expected);
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                valid_in = hold_add;
                alu_ctrl = OP_ADD; data1 = 32'd1; data2 = 32'd1; rd_in = 5'd2;
            end
            if (valid_out === 1'b1) got = 1'b1;
            else if (ready === 1'b0) busy++;
        end
        e = sb_q.pop_front();
        vectors += 5;
        if (lat != 33) begin miscompares++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        if (busy != 32) begin miscompares++; $display("FAIL mul_busy_cycles: got %0d expected 32", busy); end
        if (result !== e.res) begin miscompares++; $display("FAIL mul_result: got %h expected %h", result, e.res); end
        if (rd_out !== e.rd) begin miscompares++; $display("FAIL mul_rd: got %0d expected %0d", rd_out, e.rd); end
        if (ready !== 1'b1) begin miscompares++; $display("FAIL mul_ready_at_done: got %b expected 1", ready); end
        if (hold_add) begin
            valid_in = 1'b0;
            @(negedge clk);
            vectors++;
            if (valid_out !== 1'b0) begin miscompares++; $display("FAIL mul_held_add_leak: got valid %b rd %0d expected 0", valid_out, rd_out); end
        end else begin
            issue(OP_ADD, 32'd100, 32'd23, 5'd4, 32'd123);
            @(negedge clk);
            valid_in = 1'b0;
            e = sb_q.pop_front();
            vectors += 3;
            if (valid_out !== 1'b1) begin miscompares++; $display("FAIL post_mul_add_valid: got %b expected 1", valid_out); end
            if (result !== e.res) begin miscompares++; $display("FAIL post_mul_add_result: got %h expected %h", result, e.res); end
            if (rd_out !== e.rd) begin miscompares++; $display("FAIL post_mul_add_rd: got %0d expected %0d", rd_out, e.rd); end
        end
    endtask

    task automatic test_reset_abort();
        int stray = 0;
        @(negedge clk);
        valid_in = 1'b1;
        alu_ctrl = OP_MUL; data1 = 32'hFFFFFFFF; data2 = 32'hFFFFFFFF; rd_in = 5'd11;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (9) @(negedge clk);
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got ready %b expected 0", ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors += 5;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b expected 1", ready); end
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b expected 0", valid_out); end
        if (result !== 32'd0) begin miscompares++; $display("FAIL abort_result: got %h expected 0", result); end
        if (zero !== 1'b0) begin miscompares++; $display("FAIL abort_zero: got %b expected 0", zero); end
        if (rd_out !== 5'd0) begin miscompares++; $display("FAIL abort_rd: got %0d expected 0", rd_out); end
        repeat (40) begin
            @(negedge clk);
            if (valid_out === 1'b1) stray++;
        end
        vectors++;
        if (stray != 0) begin miscompares++; $display("FAIL abort_stray_valid: got %0d pulses expected 0", stray); end
    endtask

    task automatic test_shifts();
        logic [2:0]  ops [4] = '{OP_SLL, OP_SLL, OP_SRAI, OP_SRAI};
        logic [31:0] as  [4] = '{32'd1, 32'd1, 32'h80000001, 32'h7FFF0000};
        logic [31:0] bs  [4] = '{32'd31, 32'h21, 32'd0, 32'd16};
        logic [31:0] xs  [4] = '{32'h80000000, 32'h00000002, 32'h80000001, 32'h00007FFF};
        exp_t e;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb_q.pop_front();
                vectors += 2;
                if (valid_out !== 1'b1) begin miscompares++; $display("FAIL shift_valid[%0d]: got %b expected 1", i-1, valid_out); end
                if (result !== e.res) begin miscompares++; $display("FAIL shift_result[%0d]: got %h expected %h", i-1, result, e.res); end
            end
            if (i < 4) issue(ops[i], as[i], bs[i], 5'(i + 1), xs[i]);
            else valid_in = 1'b0;
        end
    endtask

    task automatic test_random();
        exp_t e;
        int issued = 0;
        int cyc = 0;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        while ((issued < 40 || sb_q.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (valid_out === 1'b1) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_unexpected_valid: got result %h rd %0d expected no output", result, rd_out);
                end else begin
                    e = sb_q.pop_front();
                    if (result !== e.res || rd_out !== e.rd || zero !== (e.res == 32'd0)) begin
                        miscompares++;
                        $display("FAIL rand_result: got %h/%0d/%b expected %h/%0d/%b",
                                 result, rd_out, zero, e.res, e.rd, e.res == 32'd0);
                    end
                end
            end
            if (ready === 1'b1 && issued < 40) begin
                op = 3'($urandom_range(0, 7));
                a  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
                b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
                issue(op, a, b, 5'($urandom_range(0, 31)), model(op, a, b));
                issued++;
            end else if (issued < 40) begin
                valid_in = 1'($urandom_range(0, 1));
                alu_ctrl = 3'($urandom_range(0, 7));
                data1 = $urandom; data2 = $urandom; rd_in = 5'($urandom_range(0, 31));
            end else begin
                valid_in = 1'b0;
            end
        end
        valid_in = 1'b0;
        vectors++;
        if (sb_q.size() != 0 || issued != 40) begin
            miscompares++;
            $display("FAIL rand_drain: got %0d outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_mul_step4();
        logic [31:0] as [2] = '{32'hFFFFFFFF, 32'h00001234};
        logic [31:0] bs [2] = '{32'd3, 32'h00005678};
        logic [31:0] xs [2] = '{32'hFFFFFFFD, 32'h06260060};
        int lat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            valid4_in = 1'b1;
            alu_ctrl4 = OP_MUL; data1_4 = as[i]; data2_4 = bs[i]; rd4_in = 5'd9;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                valid4_in = 1'b0;
            end while (valid4_out !== 1'b1 && lat < 50);
            vectors += 3;
            if (lat != 9) begin miscompares++; $display("FAIL mul4_latency[%0d]: got %0d expected 9", i, lat); end
            if (result4 !== xs[i]) begin miscompares++; $display("FAIL mul4_result[%0d]: got %h expected %h", i, result4, xs[i]); end
            if (rd4_out !== 5'd9) begin miscompares++; $display("FAIL mul4_rd[%0d]: got %0d expected 9", i, rd4_out); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul(1'b0, 32'hFFFFFFFF, 32'd3, 5'd9, 32'hFFFFFFFD);
        test_mul(1'b1, 32'h00001234, 32'h10, 5'd7, 32'h00012340);
        test_reset_abort();
        test_shifts();
        test_random();
        test_mul_step4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
